// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer
//   Small FIFO between the FPU output handshake and register-file writeback.
//   It captures each completed {result, tag, status}, presents the oldest
//   entry to writeback, and accrues the sticky fflags bits of every retired
//   result.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   fpu_result_i/status_i/tag_i/valid_i, fpu_ready_o
//                          FPU completion handshake (push side)
//   flush_i                drop every buffered entry
//   wb_valid_o/ready_i, wb_data_o/rd_o/status_o
//                          writeback handshake (pop side), head entry
//   fflags_wr_i/wdata_i    CSR write of fflags
//   fflags_o               sticky accrued exception flags {NV,DZ,OF,UF,NX}
//   count_o, busy_o        occupancy, non-empty
module fpu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int TAG_W = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [WIDTH-1:0]           fpu_result_i,
  input  logic [4:0]                 fpu_status_i,
  input  logic [TAG_W-1:0]           fpu_tag_i,
  input  logic                       fpu_valid_i,
  output logic                       fpu_ready_o,
  input  logic                       flush_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [WIDTH-1:0]           wb_data_o,
  output logic [TAG_W-1:0]           wb_rd_o,
  output logic [4:0]                 wb_status_o,
  input  logic                       fflags_wr_i,
  input  logic [4:0]                 fflags_wdata_i,
  output logic [4:0]                 fflags_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] rd;
    logic [4:0]       status;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [4:0]        fflags_q;
  logic              push, pop, retire;

  // Handshakes decode from registered state only: no input-to-output path.
  assign fpu_ready_o = (count_q != CNT_W'(DEPTH));
  assign wb_valid_o  = (count_q != '0);
  assign push        = fpu_valid_i & fpu_ready_o;
  assign pop         = wb_valid_o & wb_ready_i;
  assign retire      = pop & ~flush_i;

  // Storage is unreset; outputs are gated while empty instead.
  assign head        = mem[rd_ptr_q];
  assign wb_data_o   = wb_valid_o ? head.data   : '0;
  assign wb_rd_o     = wb_valid_o ? head.rd     : '0;
  assign wb_status_o = wb_valid_o ? head.status : '0;

  assign fflags_o    = fflags_q;
  assign count_o     = count_q;
  assign busy_o      = wb_valid_o;

  always_ff @(posedge clk_i) begin
    if (push && !flush_i)
      mem[wr_ptr_q] <= '{data: fpu_result_i, rd: fpu_tag_i, status: fpu_status_i};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A CSR write replaces the flags, but the status retiring in that same
  // cycle must still be accrued on top so it is not lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      fflags_q <= '0;
    else if (fflags_wr_i)
      fflags_q <= fflags_wdata_i | (retire ? wb_status_o : 5'b0);
    else if (retire)
      fflags_q <= fflags_q | wb_status_o;
  end

  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CNT_W'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && count_q == '0));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && count_q == CNT_W'(DEPTH)));
  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wb_valid_o && !wb_ready_i && !flush_i) |=>
      (wb_valid_o && $stable(wb_data_o) && $stable(wb_rd_o) && $stable(wb_status_o)));

endmodule

// File: tb/tb_fpu_result_buffer.sv
module tb_fpu_result_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk_i = 0, rst_ni = 0;
  logic [WIDTH-1:0] fpu_result_i = '0;
  logic [4:0]       fpu_status_i = '0;
  logic [TAG_W-1:0] fpu_tag_i = '0;
  logic             fpu_valid_i = 0, fpu_ready_o, flush_i = 0;
  logic             wb_valid_o, wb_ready_i = 0;
  logic [WIDTH-1:0] wb_data_o;
  logic [TAG_W-1:0] wb_rd_o;
  logic [4:0]       wb_status_o;
  logic             fflags_wr_i = 0;
  logic [4:0]       fflags_wdata_i = '0, fflags_o;
  logic [CNT_W-1:0] count_o;
  logic             busy_o;

  fpu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .flush_i(flush_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_rd_o(wb_rd_o), .wb_status_o(wb_status_o),
    .fflags_wr_i(fflags_wr_i), .fflags_wdata_i(fflags_wdata_i), .fflags_o(fflags_o),
    .count_o(count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: an ordered queue of pending results plus a flag word.
  typedef struct {
    logic [WIDTH-1:0] d;
    logic [TAG_W-1:0] rd;
    logic [4:0]       st;
  } ent_t;

  ent_t       q[$];
  logic [4:0] ff_m;
  int         checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit e;
    e = (q.size() == 0);
    chk("wb_valid",  64'(wb_valid_o),  64'(!e));
    chk("wb_data",   64'(wb_data_o),   e ? 64'd0 : 64'(q[0].d));
    chk("wb_rd",     64'(wb_rd_o),     e ? 64'd0 : 64'(q[0].rd));
    chk("wb_status", 64'(wb_status_o), e ? 64'd0 : 64'(q[0].st));
    chk("fpu_ready", 64'(fpu_ready_o), 64'(q.size() != DEPTH));
    chk("count",     64'(count_o),     64'(q.size()));
    chk("busy",      64'(busy_o),      64'(!e));
    chk("fflags",    64'(fflags_o),    64'(ff_m));
  endtask

  // Check current outputs, advance the model by one cycle, then clock.
  task automatic step();
    bit push, pop, retire;
    logic [4:0] st;
    check_model();
    push   = fpu_valid_i && (q.size() < DEPTH);
    pop    = (q.size() > 0) && wb_ready_i;
    st     = pop ? q[0].st : 5'd0;
    retire = pop && !flush_i;
    if (flush_i) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{d: fpu_result_i, rd: fpu_tag_i, st: fpu_status_i});
    end
    if (fflags_wr_i) ff_m = fflags_wdata_i | (retire ? st : 5'd0);
    else if (retire) ff_m = ff_m | st;
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    fpu_valid_i = 0; flush_i = 0; fflags_wr_i = 0; fflags_wdata_i = '0;
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t, input logic [4:0] s);
    fpu_valid_i = 1; fpu_result_i = d; fpu_tag_i = t; fpu_status_i = s;
  endtask

  initial begin
    ff_m = '0;
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_ready",    64'(fpu_ready_o), 64'd1);
    chk("rst_count",    64'(count_o), 64'd0);
    chk("rst_fflags",   64'(fflags_o), 64'd0);
    chk("rst_data",     64'(wb_data_o), 64'd0);
    rst_ni = 1;
    step();

    // Single result
    wb_ready_i = 1;
    drive(32'h3F800000, 5'd5, 5'h01);
    step();
    idle();
    chk("t1_valid", 64'(wb_valid_o), 64'd1);
    chk("t1_data",  64'(wb_data_o), 64'h3F800000);
    chk("t1_rd",    64'(wb_rd_o), 64'd5);
    step();
    chk("t1_fflags", 64'(fflags_o), 64'h01);
    chk("t1_count",  64'(count_o), 64'd0);

    // Fill under stall, third push held until space frees
    wb_ready_i = 0;
    drive(32'h1, 5'd1, 5'h00); step();
    drive(32'h2, 5'd2, 5'h00); step();
    drive(32'h3, 5'd3, 5'h00);
    chk("t2_full_ready", 64'(fpu_ready_o), 64'd0);
    step(); step();
    chk("t2_held_count", 64'(count_o), 64'd2);
    wb_ready_i = 1;
    chk("t2_head1", 64'(wb_rd_o), 64'd1);
    step();
    chk("t2_ready_back", 64'(fpu_ready_o), 64'd1);
    chk("t2_head2", 64'(wb_rd_o), 64'd2);
    step();
    idle();
    chk("t2_head3", 64'(wb_rd_o), 64'd3);
    step();
    chk("t2_empty", 64'(wb_valid_o), 64'd0);

    // Simultaneous push/pop at count=1 through pointer wrap
    wb_ready_i = 0;
    drive(32'hA000_0000, 5'd10, 5'h00); step();
    wb_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      drive($urandom, TAG_W'(i), 5'h00);
      step();
      chk("t3_count1", 64'(count_o), 64'd1);
    end
    idle(); step();

    // Flush with count=2 plus push and pop in the same cycle
    fflags_wr_i = 1; fflags_wdata_i = 5'h04; step(); idle();
    wb_ready_i = 0;
    drive(32'hF1, 5'd7, 5'h10); step();
    drive(32'hF2, 5'd8, 5'h10); step();
    chk("t4_count2", 64'(count_o), 64'd2);
    drive(32'hF3, 5'd9, 5'h10);
    flush_i = 1; wb_ready_i = 1;
    step(); idle();
    chk("t4_count0", 64'(count_o), 64'd0);
    chk("t4_valid0", 64'(wb_valid_o), 64'd0);
    chk("t4_fflags", 64'(fflags_o), 64'h04);

    // CSR write colliding with a retiring pop
    fflags_wr_i = 1; fflags_wdata_i = 5'h1F; wb_ready_i = 0;
    drive(32'hC0, 5'd4, 5'h08); step(); idle();
    fflags_wr_i = 1; fflags_wdata_i = 5'h00; wb_ready_i = 1;
    step(); idle();
    chk("t5_fflags", 64'(fflags_o), 64'h08);

    // Asynchronous reset mid-operation
    wb_ready_i = 0;
    drive(32'hD1, 5'd1, 5'h02); step();
    drive(32'hD2, 5'd2, 5'h02); step(); idle();
    chk("t6_count2", 64'(count_o), 64'd2);
    #3 rst_ni = 0;
    #1;
    chk("t6_valid", 64'(wb_valid_o), 64'd0);
    chk("t6_ready", 64'(fpu_ready_o), 64'd1);
    chk("t6_fflags", 64'(fflags_o), 64'd0);
    chk("t6_count", 64'(count_o), 64'd0);
    q.delete(); ff_m = '0;
    @(posedge clk_i); #1;
    rst_ni = 1;
    step();

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      fpu_valid_i    = ($urandom_range(0, 3) != 0);
      fpu_result_i   = $urandom;
      fpu_tag_i      = TAG_W'($urandom);
      fpu_status_i   = 5'($urandom);
      wb_ready_i     = ($urandom_range(0, 2) != 0);
      flush_i        = ($urandom_range(0, 19) == 0);
      fflags_wr_i    = ($urandom_range(0, 14) == 0);
      fflags_wdata_i = 5'($urandom);
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
